// File: rtl/flow_pkg.sv
// Shared types for the flow-control buffer controller: occupancy states and output mux selects.
package flow_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } flow_state_e;

  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_RAM  = 2'b10;
  localparam logic [1:0] SEL_REG  = 2'b11;  // reserved, never driven

  function automatic flow_state_e state_for_count(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0) begin
      return EMPTY;
    end else if (cnt >= depth) begin
      return FULL;
    end else begin
      return PARTIAL;
    end
  endfunction

endpackage

// File: rtl/flow_ptr.sv
// AW-bit wrapping pointer with increment and synchronous clear; wraps by natural overflow.
module flow_ptr #(
  parameter int AW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/flow_buf_ctrl.sv
// Show-ahead FIFO controller for the external DEPTH-entry RAM + output mux; only WE is combinational.
// Optional FLOW_BUF_CTRL_STALL_CNT_EN adds a saturating STALL_CNT of cycles with Valid_o & !Ready_i.
module flow_buf_ctrl
  import flow_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          Valid_i,
  output logic          Ready_o,
  output logic          Valid_o,
  input  logic          Ready_i,
  input  logic          FLUSH,
  output logic          WE,
  output logic [AW-1:0] WADDR,
  output logic [AW-1:0] RADDR,
  output logic [1:0]    SEL,
  output logic [AW:0]   COUNT
`ifdef FLOW_BUF_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]   STALL_CNT
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  flow_state_e   state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic          valid_q, ready_q;
  logic [1:0]    sel_q;
  logic          clr, push, pop;

  // Reset and flush share one clear path; both suppress the handshakes for that cycle.
  assign clr  = RESET | FLUSH;
  assign push = Valid_i & ready_q & ~clr;
  assign pop  = valid_q & Ready_i & ~clr;

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    case (state_q)
      EMPTY: begin
        if (push) state_d = PARTIAL;
      end
      PARTIAL: begin
        if (push && !pop && count_q == LAST_C) begin
          state_d = FULL;
        end else if (pop && !push && count_q == ONE_C) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) state_d = PARTIAL;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      state_q <= EMPTY;
      count_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      sel_q   <= SEL_IDLE;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
      sel_q   <= (state_d != EMPTY) ? SEL_RAM : SEL_IDLE;
    end
  end

  flow_ptr #(.AW(AW)) u_wr_ptr (
    .clk_i (CLK),
    .rst_i (RESET),
    .clr_i (FLUSH),
    .inc_i (push),
    .ptr_o (WADDR)
  );

  flow_ptr #(.AW(AW)) u_rd_ptr (
    .clk_i (CLK),
    .rst_i (RESET),
    .clr_i (FLUSH),
    .inc_i (pop),
    .ptr_o (RADDR)
  );

  assign WE      = push;
  assign Ready_o = ready_q;
  assign Valid_o = valid_q;
  assign SEL     = sel_q;
  assign COUNT   = count_q;

`ifdef FLOW_BUF_CTRL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (valid_q && !Ready_i && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign STALL_CNT = stall_q;
`endif

  always_ff @(posedge CLK) begin
    if (!clr) begin
      assert (count_d <= DEPTH_C)
        else $error("flow_buf_ctrl: occupancy overflow");
      assert (!(pop && count_q == '0))
        else $error("flow_buf_ctrl: pop from empty buffer");
      assert (!(push && count_q == DEPTH_C))
        else $error("flow_buf_ctrl: push into full buffer");
      assert (state_q == state_for_count({{(31-AW){1'b0}}, count_q}, DEPTH))
        else $error("flow_buf_ctrl: state inconsistent with occupancy");
    end
  end

endmodule

// File: tb/tb_flow_buf_ctrl.sv
// Scoreboard bench for flow_buf_ctrl: bench-side RAM model, tag queue checked at every pop.
module tb_flow_buf_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          Valid_i = 1'b0;
  logic          Ready_i = 1'b0;
  logic          FLUSH = 1'b0;
  logic          Ready_o, Valid_o, WE;
  logic [AW-1:0] WADDR, RADDR;
  logic [1:0]    SEL;
  logic [AW:0]   COUNT;
`ifdef FLOW_BUF_CTRL_STALL_CNT_EN
  logic [15:0]   STALL_CNT;
`endif

  flow_buf_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .Valid_i (Valid_i),
    .Ready_o (Ready_o),
    .Valid_o (Valid_o),
    .Ready_i (Ready_i),
    .FLUSH   (FLUSH),
    .WE      (WE),
    .WADDR   (WADDR),
    .RADDR   (RADDR),
    .SEL     (SEL),
    .COUNT   (COUNT)
`ifdef FLOW_BUF_CTRL_STALL_CNT_EN
    ,
    .STALL_CNT (STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_cnt    = 0;
  logic [7:0]  ram [DEPTH];
  logic [7:0]  data_tag = 8'h10;
  logic [7:0]  sb_q [$];

  // One cycle: drive at negedge, sample combinational outputs, update scoreboard, return at next negedge.
  task automatic step(input logic v, input logic r, input logic f, input logic rst,
                      output logic we_s, output logic [AW-1:0] wa_s, output logic [AW-1:0] ra_s);
    logic       m_push, m_pop;
    logic [7:0] exp;
    Valid_i = v; Ready_i = r; FLUSH = f; RESET = rst;
    #1;
    we_s = WE; wa_s = WADDR; ra_s = RADDR;
    m_push = v && (m_cnt != DEPTH) && !f && !rst;
    m_pop  = r && (m_cnt != 0) && !f && !rst;
    if (m_pop) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_empty: model popped with no queued beat");
      end else begin
        exp = sb_q.pop_front();
        if (ram[RADDR] !== exp) $display("FAIL sb_data: got %0h expected %0h (RADDR %0d)", ram[RADDR], exp, RADDR);
        else n_pass++;
      end
    end
    if (f || rst) begin
      m_cnt = 0;
      sb_q.delete();
    end else begin
      if (m_push) begin sb_q.push_back(data_tag); m_cnt++; end
      if (m_pop) m_cnt--;
    end
    @(posedge CLK);
    if (we_s) ram[wa_s] = data_tag;
    if (m_push) data_tag++;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    logic we; logic [AW-1:0] wa, ra;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, we, wa, ra);
      n_checks++; if (we !== 1'b0) $display("FAIL reset_we: got %b expected 0", we); else n_pass++;
    end
    RESET = 1'b0; Valid_i = 1'b0; Ready_i = 1'b0;
    #1;
    n_checks++; if (Ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", Ready_o); else n_pass++;
    n_checks++; if (Valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", Valid_o); else n_pass++;
    n_checks++; if (COUNT !== 3'd0) $display("FAIL reset_count: got %0d expected 0", COUNT); else n_pass++;
    n_checks++; if (SEL !== 2'b00) $display("FAIL reset_sel: got %b expected 00", SEL); else n_pass++;
    n_checks++; if (WE !== 1'b0) $display("FAIL reset_we_idle: got %b expected 0", WE); else n_pass++;
    n_checks++; if (WADDR !== 2'd0 || RADDR !== 2'd0) $display("FAIL reset_ptrs: got %0d/%0d expected 0/0", WADDR, RADDR); else n_pass++;
  endtask

  task automatic test_fill();
    logic we; logic [AW-1:0] wa, ra;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, we, wa, ra);
      n_checks++; if (we !== (i < 4)) $display("FAIL fill_we[%0d]: got %b expected %b", i, we, (i < 4)); else n_pass++;
      if (i < 4) begin
        n_checks++; if (wa !== 2'(i)) $display("FAIL fill_waddr[%0d]: got %0d expected %0d", i, wa, i); else n_pass++;
      end
      n_checks++; if (COUNT !== 3'((i < 4) ? i + 1 : 4)) $display("FAIL fill_count[%0d]: got %0d expected %0d", i, COUNT, (i < 4) ? i + 1 : 4); else n_pass++;
      n_checks++; if (Valid_o !== 1'b1) $display("FAIL fill_valid[%0d]: got %b expected 1", i, Valid_o); else n_pass++;
    end
    n_checks++; if (Ready_o !== 1'b0) $display("FAIL full_ready: got %b expected 0", Ready_o); else n_pass++;
    n_checks++; if (SEL !== 2'b10) $display("FAIL full_sel: got %b expected 10", SEL); else n_pass++;
  endtask

  task automatic test_drain_wrap();
    logic we; logic [AW-1:0] wa, ra;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, we, wa, ra);
      n_checks++; if (ra !== 2'(i)) $display("FAIL drain_raddr[%0d]: got %0d expected %0d", i, ra, i); else n_pass++;
      n_checks++; if (COUNT !== 3'(3 - i)) $display("FAIL drain_count[%0d]: got %0d expected %0d", i, COUNT, 3 - i); else n_pass++;
      n_checks++; if (Valid_o !== (i != 3)) $display("FAIL drain_valid[%0d]: got %b expected %b", i, Valid_o, (i != 3)); else n_pass++;
    end
    n_checks++; if (SEL !== 2'b00) $display("FAIL drain_sel: got %b expected 00", SEL); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, we, wa, ra);
      n_checks++; if (we !== 1'b1 || wa !== 2'(i)) $display("FAIL wrap_waddr[%0d]: got we=%b addr=%0d expected we=1 addr=%0d", i, we, wa, i); else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    logic we; logic [AW-1:0] wa, ra;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, we, wa, ra);
      n_checks++; if (2'(wa - ra) !== 2'd2) $display("FAIL simul_ptrdiff[%0d]: got %0d expected 2", i, 2'(wa - ra)); else n_pass++;
      n_checks++; if (COUNT !== 3'd2) $display("FAIL simul_count[%0d]: got %0d expected 2", i, COUNT); else n_pass++;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, we, wa, ra);
    step(1'b1, 1'b0, 1'b0, 1'b0, we, wa, ra);
    n_checks++; if (COUNT !== 3'd4) $display("FAIL simul_full: got %0d expected 4", COUNT); else n_pass++;
    step(1'b1, 1'b1, 1'b0, 1'b0, we, wa, ra);
    n_checks++; if (we !== 1'b0) $display("FAIL full_both_we: got %b expected 0", we); else n_pass++;
    n_checks++; if (COUNT !== 3'd3 || Ready_o !== 1'b1) $display("FAIL full_both_count: got %0d ready=%b expected 3 ready=1", COUNT, Ready_o); else n_pass++;
  endtask

  task automatic test_flush();
    logic we; logic [AW-1:0] wa, ra;
    step(1'b1, 1'b0, 1'b1, 1'b0, we, wa, ra);
    n_checks++; if (we !== 1'b0) $display("FAIL flush_we: got %b expected 0", we); else n_pass++;
    n_checks++; if (COUNT !== 3'd0) $display("FAIL flush_count: got %0d expected 0", COUNT); else n_pass++;
    n_checks++; if (Valid_o !== 1'b0 || Ready_o !== 1'b1 || SEL !== 2'b00) $display("FAIL flush_flags: got valid=%b ready=%b sel=%b expected 0/1/00", Valid_o, Ready_o, SEL); else n_pass++;
    n_checks++; if (WADDR !== 2'd0 || RADDR !== 2'd0) $display("FAIL flush_ptrs: got %0d/%0d expected 0/0", WADDR, RADDR); else n_pass++;
  endtask

  task automatic test_empty_pop();
    logic we; logic [AW-1:0] wa, ra;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, we, wa, ra);
      n_checks++; if (RADDR !== 2'd0 || COUNT !== 3'd0) $display("FAIL empty_pop[%0d]: got raddr=%0d count=%0d expected 0/0", i, RADDR, COUNT); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic we; logic [AW-1:0] wa, ra;
    step(1'b1, 1'b1, 1'b0, 1'b0, we, wa, ra);
    n_checks++; if (COUNT !== 3'd1 || Valid_o !== 1'b1) $display("FAIL b2b_first: got count=%0d valid=%b expected 1/1", COUNT, Valid_o); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, we, wa, ra);
      n_checks++; if (COUNT !== 3'd1) $display("FAIL b2b_count[%0d]: got %0d expected 1", i, COUNT); else n_pass++;
    end
    for (int i = 0; i < 8 && m_cnt > 0; i++) step(1'b0, 1'b1, 1'b0, 1'b0, we, wa, ra);
    n_checks++; if (COUNT !== 3'd0 || Valid_o !== 1'b0) $display("FAIL b2b_drain: got count=%0d valid=%b expected 0/0", COUNT, Valid_o); else n_pass++;
  endtask

`ifdef FLOW_BUF_CTRL_STALL_CNT_EN
  task automatic test_stall_cnt();
    logic we; logic [AW-1:0] wa, ra;
    step(1'b0, 1'b0, 1'b1, 1'b0, we, wa, ra);
    step(1'b1, 1'b0, 1'b0, 1'b0, we, wa, ra);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, we, wa, ra);
    n_checks++; if (STALL_CNT !== 16'd3) $display("FAIL stall_small: got %0d expected 3", STALL_CNT); else n_pass++;
    for (int i = 0; i < 70000; i++) step(1'b0, 1'b0, 1'b0, 1'b0, we, wa, ra);
    n_checks++; if (STALL_CNT !== 16'hFFFF) $display("FAIL stall_sat: got %h expected ffff", STALL_CNT); else n_pass++;
    step(1'b0, 1'b0, 1'b1, 1'b0, we, wa, ra);
    n_checks++; if (STALL_CNT !== 16'd0) $display("FAIL stall_flush: got %0d expected 0", STALL_CNT); else n_pass++;
  endtask
`endif

  initial begin
    @(negedge CLK);
    test_reset();
    test_fill();
    test_drain_wrap();
    test_simultaneous();
    test_flush();
    test_empty_pop();
    test_back_to_back();
`ifdef FLOW_BUF_CTRL_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flow_buf_ctrl.md
Name: flow_buf_ctrl

Overview:
Controller that sequences the 8-bit flow-control buffer datapath (DEPTH-entry async-read RAM plus 4:1 output mux) as a show-ahead FIFO with valid/ready handshakes on both sides. It generates RAM write enable and addresses, the mux select, and both handshake outputs. It replaces the fixed delay-line timing with occupancy-based control. It sits between the upstream producer and the downstream consumer; the datapath itself stays outside.

Parameters:
DEPTH, 4, number of buffer entries; power of two, minimum 2
AW, 2, address width; must equal log2(DEPTH)

Ports:
CLK  input  1  single clock; all state changes on rising edge
RESET  input  1  synchronous, active-high reset
Valid_i  input  1  upstream data valid
Ready_o  output  1  controller can accept upstream data
Valid_o  output  1  buffer head valid for downstream
Ready_i  input  1  downstream accepts head
FLUSH  input  1  synchronous discard of all buffered entries
WE  output  1  RAM write enable, one cycle per accepted beat
WADDR  output  AW  RAM write address
RADDR  output  AW  RAM read address (head entry)
SEL  output  2  output mux select: 2'b10 = RAM out, 2'b00 = idle (zero)
COUNT  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Interface fixed: one clock CLK; RESET synchronous active-high.
- Reset: wr_ptr=0, rd_ptr=0, COUNT=0, state=EMPTY, Valid_o=0, Ready_o=1, WE=0, SEL=2'b00, WADDR=RADDR=0.
- States: EMPTY (COUNT=0), PARTIAL (0<COUNT<DEPTH), FULL (COUNT=DEPTH); state register is kept explicitly and always consistent with COUNT.
- Ready_o = (state!=FULL); Valid_o = (state!=EMPTY); SEL = Valid_o ? 2'b10 : 2'b00. All are decoded from registered state only. There is no combinational path from Valid_i or Ready_i to any output except WE.
- push = Valid_i & Ready_o. WE = push, combinational, same cycle. WADDR = wr_ptr.
- pop = Valid_o & Ready_i. RADDR = rd_ptr; the head data is valid on the RAM output while Valid_o=1.
- On the edge: push increments wr_ptr; pop increments rd_ptr. Pointers wrap modulo DEPTH (natural AW-bit overflow).
- COUNT update: +1 on push only, -1 on pop only, unchanged on push&pop.
- Transitions: EMPTY->PARTIAL on push; PARTIAL->FULL on push&!pop when COUNT=DEPTH-1; PARTIAL->EMPTY on pop&!push when COUNT=1; FULL->PARTIAL on pop. Otherwise the state holds.
- Latency: a beat written in cycle N is visible at Valid_o in cycle N+1 at the earliest. There is no bypass.
- FULL with Valid_i&Ready_i: pop occurs, push is refused (Ready_o=0). The result is PARTIAL, COUNT=DEPTH-1.
- EMPTY with Ready_i: no pop; the pointers do not move.
- FLUSH: has priority over push and pop. WE is forced to 0 in that cycle. Next state is the reset state except that Ready_o=1. Pointers return to 0.
- RESET asserted mid-stream: same as FLUSH. Contents are lost and the RAM contents are don't-care.
- COUNT never exceeds DEPTH and never underflows. Violations are assertion failures.

Optional Feature:
FLOW_BUF_CTRL_STALL_CNT_EN. When defined: adds output STALL_CNT [15:0], a saturating count of cycles with Valid_o&!Ready_i. It is cleared by RESET or FLUSH and holds at 16'hFFFF. When undefined: the port and the counter do not exist, and all other behaviour is identical.

Decomposition:
- Shared package flow_pkg: state typedef {EMPTY, PARTIAL, FULL}, and SEL constants SEL_IDLE=2'b00 and SEL_RAM=2'b10. SEL_REG=2'b11 is reserved.
- One natural sub-module: flow_ptr, an AW-bit wrapping pointer with increment and clear. It is instantiated twice, once for write and once for read.

Test Plan:
- Reset: hold RESET 2 cycles, then release -> Ready_o=1, Valid_o=0, COUNT=0, SEL=00, WE=0.
- Fill: Valid_i=1, Ready_i=0 for 5 cycles -> WE pulses on 4 cycles with WADDR 0,1,2,3. FULL after the 4th push, Ready_o=0, COUNT=4, and the 5th beat is not written.
- Drain with wrap: from FULL, Ready_i=1, Valid_i=0 -> RADDR 0,1,2,3. Valid_o drops after the 4th pop. Then push 2 more beats -> WADDR 0,1 (wrap).
- Simultaneous: COUNT=2 with Valid_i=Ready_i=1 for 10 cycles -> COUNT stays 2, WADDR-RADDR stays 2 mod 4. At FULL with both high -> COUNT=3 the next cycle.
- Flush: COUNT=3 with FLUSH=1 and Valid_i=1 -> WE=0 that cycle. The next cycle gives COUNT=0, Valid_o=0, pointers=0.
- Stall counter (macro on): Valid_o=1, Ready_i=0 for 70000 cycles -> STALL_CNT=16'hFFFF. FLUSH -> 0.
